mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter RD_LAT, default 4, main-memory read latency in cycles, legal range 1..15.
REQ-002 SHALL have parameter WR_LAT, default 4, main-memory write latency in cycles, legal range 1..15.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1, the cache has a request.
REQ-006 SHALL have port req_ready, output, 1, the controller accepts the request this cycle.
REQ-007 SHALL have port req_op, input, 2, the operation: 0=READ, 1=WRITE, 2=WB_READ, 3=reserved and treated as READ.
REQ-008 SHALL have port req_addr, input, PA_WIDTH, the refill or write address.
REQ-009 SHALL have port req_wb_addr, input, PA_WIDTH, the victim address, used only by WB_READ.
REQ-010 SHALL have port req_wdata, input, BLK_WIDTH, the write or victim block data.
REQ-011 SHALL have port rsp_valid, output, 1, a completion is pending.
REQ-012 SHALL have port rsp_ready, input, 1, the cache consumes the completion.
REQ-013 SHALL have port rsp_rdata, output, BLK_WIDTH, the refill block; holds zero after a WRITE.
REQ-014 SHALL have ports mem_addr (output, PA_WIDTH), mem_rd_en (output, 1), mem_wr_en (output, 1), mem_wr_data (output, BLK_WIDTH) and mem_rd_data (input, BLK_WIDTH), connecting to the main-memory block.

Function
REQ-015 SHALL implement the FSM states IDLE, WR_WAIT, RD_WAIT and RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE with rst low; a request is accepted when req_valid and req_ready are both high.
REQ-017 SHALL register req_op, both addresses and req_wdata on accept; later input changes have no effect on the operation.
REQ-018 SHALL force the low log2(BLK_WIDTH/BYTE) bits of both registered addresses to zero (block alignment).
REQ-019 SHALL, on accept, go from IDLE to RD_WAIT for READ (cnt=RD_LAT-1), or to WR_WAIT for WRITE and WB_READ (cnt=WR_LAT-1).
REQ-020 SHALL decrement cnt by one each cycle in WR_WAIT and RD_WAIT; cnt is 4 bits wide and never wraps below 0.
REQ-021 SHALL, in WR_WAIT with cnt==0, assert mem_wr_en for exactly that one cycle, with mem_addr set to the write address and mem_wr_data set to the registered data.
REQ-022 SHALL define the write address as req_addr for WRITE and req_wb_addr for WB_READ.
REQ-023 SHALL, at the end of WR_WAIT, go to RESP for WRITE, or to RD_WAIT with cnt=RD_LAT-1 for WB_READ.
REQ-024 SHALL, in RD_WAIT with cnt==0, assert mem_rd_en for exactly that one cycle with mem_addr set to the refill address, capture mem_rd_data into rsp_rdata on that edge, and go to RESP.
REQ-025 SHALL assert rsp_valid in RESP and hold it, with rsp_rdata stable, until rsp_ready is high; it then returns to IDLE and does not accept a new request in that same cycle.
REQ-026 SHALL give the following latencies for accept at edge T with rsp_ready held high: rsp_valid first high at T+RD_LAT+1 (READ), T+WR_LAT+1 (WRITE) and T+WR_LAT+RD_LAT+1 (WB_READ).
REQ-027 SHALL never assert mem_rd_en and mem_wr_en in the same cycle.
REQ-028 SHALL keep mem_addr and mem_wr_data at zero whenever neither enable is high.
REQ-029 SHALL, with WB_READ where req_wb_addr==req_addr after alignment, still write first, so the read returns the written data.

Reset
REQ-030 SHALL, with rst high, on the next edge set the state to IDLE, cnt=0, and rsp_valid, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data and rsp_rdata all to 0.
REQ-031 SHALL drive req_ready=0 while rst is high.
REQ-032 SHALL, on reset during WR_WAIT or RD_WAIT, abort the operation: no memory enable is issued after the reset edge, and no response is produced.

Structure
REQ-033 SHALL take PA_WIDTH, BLK_WIDTH, WRD_WIDTH, BYTE and the op encodings (OP_READ, OP_WRITE, OP_WB_READ) from the shared macros package; the FSM state encoding stays local.
REQ-034 SHALL be a single module with no sub-modules; the top-level testbench instantiates it directly ahead of mem.

Verification
REQ-035 SHALL cover READ at addr 0x0047 with RD_LAT=4 and BLK_WIDTH=512: exactly one mem_rd_en pulse with mem_addr=0x0040, and rsp_valid first high 5 cycles after accept with rsp_rdata equal to the seeded block at 0x40.
REQ-036 SHALL cover WRITE at 0x0080 with data all-0xA5, WR_LAT=2: a single mem_wr_en pulse 2 cycles after accept, rsp_valid at +3, rsp_rdata=0, and a later READ of 0x0080 returning all-0xA5.
REQ-037 SHALL cover WB_READ with wb_addr=0x00C0, addr=0x0100, WR_LAT=3, RD_LAT=4: the write pulse at +3, the read pulse at +7, rsp_valid at +8, and 0x00C0 then holding the victim data.
REQ-038 SHALL cover rsp_ready held low for 6 cycles: rsp_valid and rsp_rdata stay stable, req_ready stays 0, and IDLE is reached one cycle after rsp_ready rises.
REQ-039 SHALL cover rst asserted at the second cycle of WR_WAIT: no mem_wr_en ever fires, memory is unchanged, rsp_valid=0, and req_ready=1 on the cycle after rst falls.
REQ-040 SHALL cover back-to-back requests with req_valid held high: the second is accepted only after the RESP-to-IDLE cycle, and mem_rd_en and mem_wr_en are never high together.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared widths, op encodings and request record for the memory controller.
package mem_ctrl_pkg;
  localparam int PA_WIDTH = 16;
  localparam int BLK_WIDTH = 512;
  localparam int WRD_WIDTH = 64;
  localparam int BYTE = 8;
  localparam int BLK_OFF = $clog2(BLK_WIDTH / BYTE);
  localparam logic [1:0] OP_READ = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_WB_READ = 2'd2;
  typedef logic [PA_WIDTH-1:0] pa_t;
  typedef logic [BLK_WIDTH-1:0] blk_t;
  typedef struct packed {
    logic [1:0] op;
    pa_t addr;
    pa_t wb_addr;
    blk_t wdata;
  } req_t;
  function automatic pa_t blk_align(input pa_t a);
    return a & ~PA_WIDTH'((1 << BLK_OFF) - 1);
  endfunction
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises cache READ / WRITE / WB_READ requests onto a single-port main memory.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RD_LAT = 4,
  parameter int WR_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [PA_WIDTH-1:0]  req_addr,
  input  logic [PA_WIDTH-1:0]  req_wb_addr,
  input  logic [BLK_WIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BLK_WIDTH-1:0] rsp_rdata,
  output logic [PA_WIDTH-1:0]  mem_addr,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [BLK_WIDTH-1:0] mem_wr_data,
  input  logic [BLK_WIDTH-1:0] mem_rd_data
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR_WAIT = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;
  localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  req_t r_q, r_d;
  logic rsp_valid_q, rsp_valid_d;
  blk_t rsp_rdata_q, rsp_rdata_d;
  logic mem_rd_en_q, mem_rd_en_d;
  logic mem_wr_en_q, mem_wr_en_d;
  pa_t mem_addr_q, mem_addr_d;
  blk_t mem_wr_data_q, mem_wr_data_d;
  logic accept, fire, waiting, is_wb, req_rd;
  assign req_ready = (state_q == IDLE) && !rst;
  assign accept = req_valid && req_ready;
  assign waiting = (state_q == WR_WAIT) || (state_q == RD_WAIT);
  assign fire = waiting && (cnt_q == 4'd0);
  assign is_wb = r_q.op == OP_WB_READ;
  assign req_rd = (req_op != OP_WRITE) && (req_op != OP_WB_READ);
  // Enables are registered: the pulse appears the cycle after the countdown reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d = (waiting && !fire) ? cnt_q - 4'd1 : cnt_q;
    r_d = accept ? req_t'{op: req_op, addr: blk_align(req_addr), wb_addr: blk_align(req_wb_addr), wdata: req_wdata} : r_q;
    mem_wr_en_d = fire && (state_q == WR_WAIT);
    mem_rd_en_d = fire && (state_q == RD_WAIT);
    mem_addr_d = mem_wr_en_d ? (is_wb ? r_q.wb_addr : r_q.addr) : mem_rd_en_d ? r_q.addr : '0;
    mem_wr_data_d = mem_wr_en_d ? r_q.wdata : '0;
    rsp_valid_d = rsp_valid_q ? !rsp_ready : (state_q == RESP);
    rsp_rdata_d = mem_rd_en_q ? mem_rd_data : accept ? '0 : rsp_rdata_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = req_rd ? RD_WAIT : WR_WAIT;
        cnt_d = req_rd ? RD_CNT : WR_CNT;
      end
      WR_WAIT: if (fire) begin
        state_d = is_wb ? RD_WAIT : RESP;
        cnt_d = RD_CNT;
      end
      RD_WAIT: if (fire) state_d = RESP;
      default: if (rsp_valid_q && rsp_ready) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      r_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      r_q <= r_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_addr_q <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_addr = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed requests with a scoreboard of expected memory pulses and responses.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;
  localparam int RD_LAT = 4;
  localparam int WR_LAT = 3;
  typedef struct {bit wr; pa_t addr; blk_t data; int cyc;} mev_t;
  typedef struct {blk_t data; int cyc;} rsp_t;
  logic clk = 0, rst;
  logic req_valid, req_ready, rsp_valid, rsp_ready, mem_rd_en, mem_wr_en;
  logic [1:0] req_op;
  pa_t req_addr, req_wb_addr, mem_addr;
  blk_t req_wdata, rsp_rdata, mem_wr_data, mem_rd_data;
  blk_t mem [0:(1 << (PA_WIDTH - BLK_OFF)) - 1];
  mev_t mq[$];
  rsp_t rq[$];
  int cyc = 0, vectors = 0, errors = 0;
  logic rsp_prev = 0;
  mev_t e;
  rsp_t r;

  mem_ctrl #(.RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wb_addr(req_wb_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic blk_t seed(input int i);
    blk_t s;
    for (int w = 0; w < BLK_WIDTH / WRD_WIDTH; w++)
      s[w*WRD_WIDTH +: WRD_WIDTH] = {32'hC0DE0000 | 32'(i), 32'(w)};
    return s;
  endfunction

  initial for (int i = 0; i < (1 << (PA_WIDTH - BLK_OFF)); i++) mem[i] = seed(i);
  always @(posedge clk) if (mem_wr_en) mem[mem_addr[PA_WIDTH-1:BLK_OFF]] <= mem_wr_data;
  assign mem_rd_data = mem[mem_addr[PA_WIDTH-1:BLK_OFF]];

  function automatic void chk(input string n, input logic [BLK_WIDTH-1:0] act, input logic [BLK_WIDTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", n, act, exp);
    end
  endfunction

  function automatic void miss(input string n);
    vectors++;
    errors++;
    $display("FAIL %s: got event/timeout, required none at cycle %0d", n, cyc);
  endfunction

  always @(negedge clk) begin
    if (rst) rsp_prev = 0;
    else begin
      chk("en_exclusive", {511'b0, mem_rd_en & mem_wr_en}, '0);
      if (mem_rd_en || mem_wr_en) begin
        if (mq.size() == 0) miss("unexpected_mem_en");
        else begin
          e = mq.pop_front();
          chk("mem_wr_en", {511'b0, mem_wr_en}, {511'b0, e.wr});
          chk("mem_addr", {496'b0, mem_addr}, {496'b0, e.addr});
          chk("mem_cycle", 512'(cyc), 512'(e.cyc));
          if (e.wr) chk("mem_wr_data", mem_wr_data, e.data);
        end
      end else begin
        chk("idle_mem_addr", {496'b0, mem_addr}, '0);
        chk("idle_mem_wr_data", mem_wr_data, '0);
      end
      if (rsp_valid && !rsp_prev) begin
        if (rq.size() == 0) miss("unexpected_rsp");
        else chk("rsp_latency", 512'(cyc), 512'(rq[0].cyc));
      end
      if (rsp_valid && rsp_ready && rq.size() != 0) begin
        r = rq.pop_front();
        chk("rsp_rdata", rsp_rdata, r.data);
      end
      rsp_prev = rsp_valid;
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic [1:0] op, input pa_t a, input pa_t wba, input blk_t d,
                       input blk_t exp, input bit track, input bit keep, output int t);
    int n = 0;
    req_valid = 1; req_op = op; req_addr = a; req_wb_addr = wba; req_wdata = d;
    @(negedge clk);
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) miss("accept_timeout");
    t = cyc + 1;
    if (track) begin
      if (op == OP_WRITE) begin
        mq.push_back('{1'b1, a & 16'hFFC0, d, t + WR_LAT});
        rq.push_back('{'0, t + WR_LAT + 1});
      end else if (op == OP_WB_READ) begin
        mq.push_back('{1'b1, wba & 16'hFFC0, d, t + WR_LAT});
        mq.push_back('{1'b0, a & 16'hFFC0, '0, t + WR_LAT + RD_LAT});
        rq.push_back('{exp, t + WR_LAT + RD_LAT + 1});
      end else begin
        mq.push_back('{1'b0, a & 16'hFFC0, '0, t + RD_LAT});
        rq.push_back('{exp, t + RD_LAT + 1});
      end
    end
    @(posedge clk); #1;
    if (!keep) begin
      req_valid = 0; req_addr = 16'hFFFF; req_wb_addr = 16'hFFFF; req_wdata = '1;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while ((mq.size() != 0 || rq.size() != 0 || !req_ready) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) miss("done_timeout");
  endtask

  initial begin
    int t1, t2, n;
    blk_t held;
    rst = 1; req_valid = 0; req_op = 0; req_addr = 0; req_wb_addr = 0; req_wdata = 0; rsp_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {511'b0, req_ready}, '0);
    chk("rst_rsp_valid", {511'b0, rsp_valid}, '0);
    chk("rst_enables", {510'b0, mem_rd_en, mem_wr_en}, '0);
    chk("rst_mem_addr", {496'b0, mem_addr}, '0);
    chk("rst_rsp_rdata", rsp_rdata, '0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("idle_req_ready", {511'b0, req_ready}, {511'b0, 1'b1});
    @(posedge clk); #1;
    issue(OP_READ, 16'h0047, 16'h0000, '0, seed(1), 1, 0, t1); wait_done();
    issue(OP_WRITE, 16'h0080, 16'h0000, {64{8'hA5}}, '0, 1, 0, t1); wait_done();
    issue(OP_READ, 16'h0080, 16'h0000, '0, {64{8'hA5}}, 1, 0, t1); wait_done();
    issue(OP_WB_READ, 16'h0100, 16'h00C0, {64{8'h3C}}, seed(4), 1, 0, t1); wait_done();
    issue(OP_READ, 16'h00C0, 16'h0000, '0, {64{8'h3C}}, 1, 0, t1); wait_done();
    issue(OP_WB_READ, 16'h0147, 16'h0140, {32{16'h1234}}, {32{16'h1234}}, 1, 0, t1); wait_done();
    issue(2'd3, 16'h0185, 16'h0000, '0, seed(6), 1, 0, t1); wait_done();
    rsp_ready = 0;
    issue(OP_READ, 16'h01C0, 16'h0000, '0, seed(7), 1, 0, t1);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) miss("rsp_timeout");
    held = rsp_rdata;
    for (int i = 0; i < 6; i++) begin
      chk("bp_rsp_valid", {511'b0, rsp_valid}, {511'b0, 1'b1});
      chk("bp_rsp_rdata", rsp_rdata, held);
      chk("bp_req_ready", {511'b0, req_ready}, '0);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_after", {511'b0, req_ready}, {511'b0, 1'b1});
    @(posedge clk); #1;
    issue(OP_WRITE, 16'h0203, 16'h0000, '1, '0, 0, 0, t1);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("rst_mid_req_ready", {511'b0, req_ready}, '0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("abort_req_ready", {511'b0, req_ready}, {511'b0, 1'b1});
    chk("abort_rsp_valid", {511'b0, rsp_valid}, '0);
    repeat (WR_LAT + RD_LAT + 3) @(posedge clk);
    #1;
    issue(OP_READ, 16'h0200, 16'h0000, '0, seed(8), 1, 0, t1); wait_done();
    issue(OP_READ, 16'h0240, 16'h0000, '0, seed(9), 1, 1, t1);
    issue(OP_WRITE, 16'h0280, 16'h0000, {16{32'h0BADF00D}}, '0, 1, 0, t2);
    chk("b2b_accept_cycle", 512'(t2), 512'(t1 + RD_LAT + 3));
    wait_done();
    issue(OP_READ, 16'h0280, 16'h0000, '0, {16{32'h0BADF00D}}, 1, 0, t1); wait_done();
    chk("queues_empty", 512'(mq.size() + rq.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
